// File: rtl/io_port_ctrl_if.sv
// Port bundle between the CPU-side port user, the TX device and the RX producer.
// master: drives the instruction/device inputs; slave: the io_port_ctrl responder.
interface io_port_if #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          PortWrite;
  logic          PortRead;
  logic [DW-1:0] WrData;
  logic [DW-1:0] RdData;
  logic          Stall;
  logic [DW-1:0] TxData;
  logic          TxValid;
  logic          TxReady;
  logic [DW-1:0] RxData;
  logic          RxValid;
  logic          RxReady;
  logic [CW-1:0] TxCount;
  logic          TimeoutFlag;

  modport master (
    output PortWrite, PortRead, WrData, TxReady, RxData, RxValid,
    input  RdData, Stall, TxData, TxValid, RxReady, TxCount, TimeoutFlag
  );

  modport slave (
    input  PortWrite, PortRead, WrData, TxReady, RxData, RxValid,
    output RdData, Stall, TxData, TxValid, RxReady, TxCount, TimeoutFlag
  );
endinterface

// File: rtl/io_port_ctrl.sv
// io_port_ctrl: responder for the core's OUT/IN port instructions.
// OUT words go through a DEPTH-entry TX FIFO to a valid/ready device; IN words
// come from a one-entry RX holding buffer. Stall holds the core while an OUT
// finds the FIFO full or an IN finds the RX buffer empty.
// Optional IN wait limit enabled by defining IO_TIMEOUT_EN (adds TIMEOUT param).
//
// RX buffer states:
//   state    | meaning
//   RX_OFF   | first cycle after reset release, RxReady held low
//   RX_EMPTY | buffer free, RxReady high, waiting for a device word
//   RX_FULL  | buffer holds a word for the next IN (rxv = 1)
module io_port_ctrl #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
`ifdef IO_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input logic      clk,
  input logic      reset,
  io_port_if.slave port
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {RX_OFF, RX_EMPTY, RX_FULL} rx_state_t;

  rx_state_t     rx_state, rx_state_nxt;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [DW-1:0] rx_buf;
  logic          full, rxv, to_hit, stall;
  logic          push, pop, rd_commit, rx_capture;

  assign full       = (count == CW'(DEPTH));
  assign rxv        = (rx_state == RX_FULL);
  // A timeout releases only the read-side stall; a full FIFO still holds an OUT.
  assign stall      = (port.PortWrite & full) | (port.PortRead & ~rxv & ~to_hit);
  assign push       = port.PortWrite & ~stall;
  assign pop        = (count != '0) & port.TxReady;
  assign rd_commit  = port.PortRead & ~stall;
  assign rx_capture = (rx_state == RX_EMPTY) & port.RxValid;

  assign port.Stall   = stall;
  assign port.TxValid = (count != '0);
  assign port.TxData  = mem[rd_ptr];
  assign port.TxCount = count;
  assign port.RxReady = (rx_state == RX_EMPTY);
  assign port.RdData  = rxv ? rx_buf : '0;

  // TX storage: written on an accepted OUT, no reset needed since count gates validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= port.WrData;
  end

  // TX pointers and occupancy; pointers wrap at DEPTH, count tells full from empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // RX buffer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rx_state <= RX_OFF;
    else       rx_state <= rx_state_nxt;
  end

  // RX next state: fill from the device, drain on a committed IN.
  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      RX_OFF:   rx_state_nxt = RX_EMPTY;
      RX_EMPTY: if (port.RxValid) rx_state_nxt = RX_FULL;
      RX_FULL:  if (rd_commit) rx_state_nxt = RX_EMPTY;
      default:  rx_state_nxt = RX_OFF;
    endcase
  end

  // RX data holding register, loaded only when the buffer is free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           rx_buf <= '0;
    else if (rx_capture) rx_buf <= port.RxData;
  end

`ifdef IO_TIMEOUT_EN
  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [TW-1:0] to_cnt;
  logic          to_flag;
  logic          read_wait;

  assign read_wait        = port.PortRead & ~rxv;
  assign to_hit           = read_wait & (to_cnt == TW'(TIMEOUT));
  assign port.TimeoutFlag = to_flag;

  // IN wait counter; on reaching the limit the IN is forced through with zero data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else if (!read_wait) begin
      to_cnt <= '0;
    end else if (to_hit) begin
      if (!stall) begin
        to_cnt  <= '0;
        to_flag <= 1'b1;
      end
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign to_hit           = 1'b0;
  assign port.TimeoutFlag = 1'b0;
`endif
endmodule

// File: tb/tb_io_port_ctrl.sv
// Bench for io_port_ctrl: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_io_port_ctrl;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
`ifdef IO_TIMEOUT_EN
  localparam int TIMEOUT = 8;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  io_port_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

  io_port_ctrl #(
    .DW(DW),
    .DEPTH(DEPTH)
`ifdef IO_TIMEOUT_EN
    , .TIMEOUT(TIMEOUT)
`endif
  ) dut (
    .clk  (clk),
    .reset(reset),
    .port (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [DW-1:0] q[$];
  bit            m_rxv, m_rdy, m_flag;
  logic [DW-1:0] m_rxd;
  int            m_wait;

  // predicted outputs for the current cycle
  bit            e_stall, e_txv, e_rxr, e_flag;
  logic [DW-1:0] e_txd, e_rd;
  int            e_cnt;

  typedef struct {
    bit            pw, pr;
    logic [DW-1:0] wd;
    bit            txr;
    logic [DW-1:0] rxd;
    bit            rxvi;
    bit            stall, txv;
    logic [DW-1:0] txd;
    int            cnt;
    logic [DW-1:0] rd;
    bit            rxr;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(bit pw, bit pr, logic [DW-1:0] wd, bit txr,
                              logic [DW-1:0] rxd, bit rxvi, bit stall, bit txv,
                              logic [DW-1:0] txd, int cnt, logic [DW-1:0] rd, bit rxr);
    vec_t v;
    v.pw = pw; v.pr = pr; v.wd = wd; v.txr = txr; v.rxd = rxd; v.rxvi = rxvi;
    v.stall = stall; v.txv = txv; v.txd = txd; v.cnt = cnt; v.rd = rd; v.rxr = rxr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rxv  = 0;
    m_rdy  = 0;
    m_flag = 0;
    m_rxd  = '0;
    m_wait = 0;
  endtask

  task automatic predict();
    bit read_wait, to_fire;
    read_wait = bus.PortRead && !m_rxv;
    to_fire   = 0;
`ifdef IO_TIMEOUT_EN
    to_fire   = read_wait && (m_wait >= TIMEOUT);
`endif
    e_stall = (bus.PortWrite && q.size() == DEPTH) || (read_wait && !to_fire);
    e_txv   = (q.size() != 0);
    e_txd   = e_txv ? q[0] : '0;
    e_cnt   = q.size();
    e_rd    = m_rxv ? m_rxd : '0;
    e_rxr   = m_rdy && !m_rxv;
    e_flag  = m_flag;
  endtask

  task automatic model_edge();
    bit commit, read_wait;
    commit    = !e_stall;
    read_wait = bus.PortRead && !m_rxv;
    if (e_txv && bus.TxReady) void'(q.pop_front());
    if (commit && bus.PortWrite) q.push_back(bus.WrData);
`ifdef IO_TIMEOUT_EN
    if (!read_wait) m_wait = 0;
    else if (m_wait >= TIMEOUT) begin
      if (commit) begin
        m_wait = 0;
        m_flag = 1;
      end
    end else m_wait++;
`endif
    if (commit && bus.PortRead) m_rxv = 0;
    if (e_rxr && bus.RxValid) begin
      m_rxv = 1;
      m_rxd = bus.RxData;
    end
    m_rdy = 1;
  endtask

  task automatic drive(input bit pw, input bit pr, input logic [DW-1:0] wd, input bit txr,
                       input logic [DW-1:0] rxd, input bit rxvi);
    bus.PortWrite = pw;
    bus.PortRead  = pr;
    bus.WrData    = wd;
    bus.TxReady   = txr;
    bus.RxData    = rxd;
    bus.RxValid   = rxvi;
  endtask

  // drive, then sample combinational outputs at the falling edge
  task automatic step_begin(input bit pw, input bit pr, input logic [DW-1:0] wd, input bit txr,
                            input logic [DW-1:0] rxd, input bit rxvi);
    drive(pw, pr, wd, txr, rxd, rxvi);
    @(negedge clk);
    predict();
  endtask

  task automatic step_end();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model();
    chk("stall", 32'(bus.Stall), 32'(e_stall));
    chk("txvalid", 32'(bus.TxValid), 32'(e_txv));
    if (e_txv) chk("txdata", 32'(bus.TxData), 32'(e_txd));
    chk("txcount", 32'(bus.TxCount), 32'(e_cnt));
    chk("rddata", 32'(bus.RdData), 32'(e_rd));
    chk("rxready", 32'(bus.RxReady), 32'(e_rxr));
    chk("timeout_flag", 32'(bus.TimeoutFlag), 32'(e_flag));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    drive(0, 0, '0, 0, '0, 0);
    #2;
    chk("rst_txcount", 32'(bus.TxCount), 0);
    chk("rst_txvalid", 32'(bus.TxValid), 0);
    chk("rst_rxready", 32'(bus.RxReady), 0);
    chk("rst_rddata", 32'(bus.RdData), 0);
    chk("rst_stall", 32'(bus.Stall), 0);
    chk("rst_flag", 32'(bus.TimeoutFlag), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // directed vector table, one row per cycle
    vt.push_back(mk(0,0,16'h0000,0,16'h0000,0, 0,0,16'h0000,0,16'h0000,0));
    vt.push_back(mk(1,0,16'h00A5,1,16'h0000,0, 0,0,16'h0000,0,16'h0000,1));
    vt.push_back(mk(0,0,16'h0000,1,16'h0000,0, 0,1,16'h00A5,1,16'h0000,1));
    vt.push_back(mk(0,0,16'h0000,0,16'h0000,0, 0,0,16'h0000,0,16'h0000,1));
    vt.push_back(mk(1,0,16'h0001,0,16'h0000,0, 0,0,16'h0000,0,16'h0000,1));
    vt.push_back(mk(1,0,16'h0002,0,16'h0000,0, 0,1,16'h0001,1,16'h0000,1));
    vt.push_back(mk(1,0,16'h0003,0,16'h0000,0, 0,1,16'h0001,2,16'h0000,1));
    vt.push_back(mk(1,0,16'h0004,0,16'h0000,0, 0,1,16'h0001,3,16'h0000,1));
    vt.push_back(mk(1,0,16'h0005,0,16'h0000,0, 1,1,16'h0001,4,16'h0000,1));
    vt.push_back(mk(1,0,16'h0005,1,16'h0000,0, 1,1,16'h0001,4,16'h0000,1));
    vt.push_back(mk(1,0,16'h0005,0,16'h0000,0, 0,1,16'h0002,3,16'h0000,1));
    vt.push_back(mk(0,0,16'h0000,1,16'h0000,0, 0,1,16'h0002,4,16'h0000,1));
    vt.push_back(mk(0,0,16'h0000,1,16'h0000,0, 0,1,16'h0003,3,16'h0000,1));
    vt.push_back(mk(0,0,16'h0000,1,16'h0000,0, 0,1,16'h0004,2,16'h0000,1));
    vt.push_back(mk(0,0,16'h0000,1,16'h0000,0, 0,1,16'h0005,1,16'h0000,1));
    vt.push_back(mk(0,0,16'h0000,0,16'h0000,0, 0,0,16'h0000,0,16'h0000,1));
    vt.push_back(mk(0,1,16'h0000,0,16'h0000,0, 1,0,16'h0000,0,16'h0000,1));
    vt.push_back(mk(0,1,16'h0000,0,16'h1234,1, 1,0,16'h0000,0,16'h0000,1));
    vt.push_back(mk(0,1,16'h0000,0,16'h5555,1, 0,0,16'h0000,0,16'h1234,0));
    vt.push_back(mk(0,0,16'h0000,0,16'h5555,1, 0,0,16'h0000,0,16'h0000,1));
    vt.push_back(mk(0,0,16'h0000,0,16'h0000,0, 0,0,16'h0000,0,16'h5555,0));
    vt.push_back(mk(1,0,16'h000A,0,16'h0000,0, 0,0,16'h0000,0,16'h5555,0));
    vt.push_back(mk(1,0,16'h000B,0,16'h0000,0, 0,1,16'h000A,1,16'h5555,0));
    vt.push_back(mk(1,0,16'h000C,0,16'h0000,0, 0,1,16'h000A,2,16'h5555,0));
    vt.push_back(mk(1,0,16'h000D,0,16'h0000,0, 0,1,16'h000A,3,16'h5555,0));
    vt.push_back(mk(1,1,16'h000E,0,16'h0000,0, 1,1,16'h000A,4,16'h5555,0));
    vt.push_back(mk(1,1,16'h000E,0,16'h0000,0, 1,1,16'h000A,4,16'h5555,0));
    vt.push_back(mk(0,1,16'h0000,0,16'h0000,0, 0,1,16'h000A,4,16'h5555,0));
    vt.push_back(mk(0,0,16'h0000,1,16'h0000,0, 0,1,16'h000A,4,16'h0000,1));

    for (int i = 0; i < vt.size(); i++) begin
      step_begin(vt[i].pw, vt[i].pr, vt[i].wd, vt[i].txr, vt[i].rxd, vt[i].rxvi);
      chk($sformatf("vec%0d_stall", i), 32'(bus.Stall), 32'(vt[i].stall));
      chk($sformatf("vec%0d_txvalid", i), 32'(bus.TxValid), 32'(vt[i].txv));
      if (vt[i].txv) chk($sformatf("vec%0d_txdata", i), 32'(bus.TxData), 32'(vt[i].txd));
      chk($sformatf("vec%0d_txcount", i), 32'(bus.TxCount), 32'(vt[i].cnt));
      chk($sformatf("vec%0d_rddata", i), 32'(bus.RdData), 32'(vt[i].rd));
      chk($sformatf("vec%0d_rxready", i), 32'(bus.RxReady), 32'(vt[i].rxr));
      step_end();
    end

    // randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      step_begin(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 3),
                 DW'($urandom), 1'($urandom_range(0, 1)),
                 DW'($urandom), 1'($urandom_range(0, 1)));
      check_model();
      step_end();
    end

    // fill FIFO and RX buffer, then reset mid-transfer
    for (int i = 0; i < 3; i++) begin
      step_begin(1, 0, DW'(16'h7000 + i), 0, 16'hC0DE, 1);
      check_model();
      step_end();
    end
    drive(1, 0, 16'h7777, 1, 16'h0BAD, 1);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("midrst_txcount", 32'(bus.TxCount), 0);
    chk("midrst_txvalid", 32'(bus.TxValid), 0);
    chk("midrst_rxready", 32'(bus.RxReady), 0);
    chk("midrst_rddata", 32'(bus.RdData), 0);
    @(posedge clk);
    #1;
    chk("midrst_rxready_held", 32'(bus.RxReady), 0);
    reset = 1'b0;

`ifdef IO_TIMEOUT_EN
    for (int k = 0; k < TIMEOUT; k++) begin
      step_begin(0, 1, '0, 0, '0, 0);
      chk($sformatf("to_wait%0d_stall", k), 32'(bus.Stall), 1);
      chk($sformatf("to_wait%0d_flag", k), 32'(bus.TimeoutFlag), 0);
      step_end();
    end
    step_begin(0, 1, '0, 0, '0, 0);
    chk("to_fire_stall", 32'(bus.Stall), 0);
    chk("to_fire_rddata", 32'(bus.RdData), 0);
    chk("to_fire_flag", 32'(bus.TimeoutFlag), 0);
    step_end();
    for (int k = 0; k < 4; k++) begin
      step_begin(0, 0, '0, 0, '0, 0);
      chk($sformatf("to_sticky%0d_flag", k), 32'(bus.TimeoutFlag), 1);
      step_end();
    end
    reset = 1'b1;
    #1;
    chk("to_reset_flag", 32'(bus.TimeoutFlag), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
`else
    for (int k = 0; k < 20; k++) begin
      step_begin(0, 1, '0, 0, '0, 0);
      chk($sformatf("in_wait%0d_stall", k), 32'(bus.Stall), 1);
      chk($sformatf("in_wait%0d_flag", k), 32'(bus.TimeoutFlag), 0);
      step_end();
    end
    step_begin(0, 1, '0, 0, 16'hBEEF, 1);
    chk("in_arrive_stall", 32'(bus.Stall), 1);
    step_end();
    step_begin(0, 1, '0, 0, '0, 0);
    chk("in_done_stall", 32'(bus.Stall), 0);
    chk("in_done_rddata", 32'(bus.RdData), 32'h0000BEEF);
    step_end();
`endif

    // short random tail after the reset
    for (int i = 0; i < 100; i++) begin
      step_begin(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 3),
                 DW'($urandom), 1'($urandom_range(0, 1)),
                 DW'($urandom), 1'($urandom_range(0, 1)));
      check_model();
      step_end();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/io_port_ctrl.md
Name: io_port_ctrl

Overview:
- Responder side of the CPU port interface: services the decoder's PortWrite (OUT) and IN instructions.
- OUT data is pushed into a TX FIFO that drains to an external device over a valid/ready handshake.
- IN data comes from an external producer through a one-entry RX holding buffer.
- Sits beside the register file/datapath; stalls the core whenever an OUT or IN cannot complete this cycle.

Parameters:
- DW, 16, data width of port words.
- DEPTH, 4, TX FIFO entries; power of two, >= 2.
- TIMEOUT, 255, IN wait limit in cycles; used only with IO_TIMEOUT_EN.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- PortWrite  in  1  OUT instruction this cycle.
- PortRead  in  1  IN instruction this cycle.
- WrData  in  DW  OUT operand.
- RdData  out  DW  IN result to the register-file write port.
- Stall  out  1  core must hold the current instruction.
- TxData  out  DW  FIFO head to device.
- TxValid  out  1  FIFO non-empty.
- TxReady  in  1  device accepts TxData.
- RxData  in  DW  device word.
- RxValid  in  1  device word valid.
- RxReady  out  1  RX buffer free.
- TxCount  out  $clog2(DEPTH)+1  current FIFO occupancy.
- TimeoutFlag  out  1  sticky IN-timeout indicator.

Behaviour:
- Reset (async):
  - FIFO pointers 0, TxCount 0, TxValid 0.
  - RX buffer empty; RdData 0.
  - Timeout counter 0, TimeoutFlag 0.
  - RxReady 0 while reset is high, 1 on the first edge after release.
- Stall is combinational: (PortWrite & full) | (PortRead & !rxv).
  - full means TxCount == DEPTH; rxv is the RX buffer valid bit.
- Commit rule: PortWrite and PortRead take effect only in a cycle with Stall = 0.
  - If both are high, both commit together or neither does.
- TX push: on commit of PortWrite, WrData is written at the write pointer; the pointer increments mod DEPTH.
- TX pop:
  - TxValid = (TxCount != 0); TxData = mem[rd_ptr], combinational from the registered array.
  - On TxValid & TxReady the read pointer increments mod DEPTH.
- Full/empty:
  - A push while full is never accepted; Stall holds it, even if a pop happens the same cycle.
  - A simultaneous push and pop while non-full leaves TxCount unchanged.
  - Pointers wrap silently and TxCount disambiguates full from empty.
- Latency: a word committed at edge N drives TxData/TxValid after edge N if the FIFO was empty (1 cycle).
- RX:
  - RxReady = !rxv.
  - RxValid & RxReady at an edge captures RxData and sets rxv.
  - There is no same-cycle bypass from RxData to RdData; minimum IN latency after a device transfer is 1 cycle.
- IN:
  - RdData = rx buffer when rxv = 1, else 0.
  - On commit of PortRead, rxv clears at the edge.
  - A new RxData cannot be captured in that same edge, because RxReady was 0.
- Back-to-back OUTs with TxReady held high sustain 1 word/cycle with no stall.
- RX sustains 1 word per 2 cycles with no skid.
- Reset mid-transfer discards FIFO contents and the RX buffer; an in-flight device handshake is abandoned.

Optional Feature:
- Macro IO_TIMEOUT_EN.
- With it defined:
  - A counter increments on every cycle with PortRead & !rxv.
  - When the counter equals TIMEOUT, Stall is forced 0 and PortRead commits with RdData = 0.
  - In that cycle TimeoutFlag sets (sticky until reset) and the counter clears.
  - The counter also clears on any cycle without PortRead, or when rxv = 1.
- Without it: no counter; IN stalls indefinitely; TimeoutFlag is tied 0.

Test Plan:
- Reset, then PortWrite with WrData=16'h00A5 and TxReady=1 → TxValid=1 with TxData=00A5 next cycle; popped the following edge; TxCount returns to 0.
- TxReady=0, five OUTs 1,2,3,4,5 → four accepted (TxCount=4); Stall=1 on the fifth; raise TxReady → words 1..5 emerge in order, 5 enters once space frees.
- FIFO full with PortWrite and TxReady both high → no push that cycle, TxCount 4→3, push next cycle → TxCount 4.
- PortRead with no RX data → Stall=1; RxData=16'h1234 with RxValid at edge N → Stall=0 and RdData=1234 after N; RxReady=0 until the IN commits, then 1.
- PortRead with the buffer valid plus PortWrite with the FIFO full → Stall=1, neither commits, rxv stays 1, TxCount stays 4.
- With IO_TIMEOUT_EN and TIMEOUT=8, PortRead held with no RxValid → Stall=1 for 8 cycles, then RdData=0, Stall=0, TimeoutFlag=1 until reset.
